// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: fetch, execute, data-memory wait and
// interrupt entry, with every strobe decoded combinationally from state and inputs.
module cpu_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       dec_rf_we,
  input  logic       dec_csr_en,
  input  logic       dec_is_mret,
  input  logic       intr,
  input  logic       csr_mie,
  input  logic       mem_ready,
  output logic       mem_rden1,
  output logic       ir_we,
  output logic       mem_rden2,
  output logic       mem_we2,
  output logic       pc_we,
  output logic       rf_we,
  output logic       csr_we,
  output logic       mret_exec,
  output logic       int_taken,
  output logic       bus_err,
  output logic [1:0] state_o
);

  localparam logic [1:0] S_FETCH = 2'b00;
  localparam logic [1:0] S_EXEC  = 2'b01;
  localparam logic [1:0] S_MEM   = 2'b10;
  localparam logic [1:0] S_INTR  = 2'b11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [1:0] state, state_nxt;
  logic [7:0] wait_cnt;
  logic       mem_is_load;
  logic       known_op, timeout, complete;
  logic       rden1_c, ir_we_c, rden2_c, we2_c, pc_we_c, rf_we_c;
  logic       csr_we_c, mret_c, int_c, err_c;

  always_comb begin
    case (opcode)
      OP_IMM, OP_REG, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_BRANCH, OP_FENCE, OP_SYSTEM: known_op = 1'b1;
      default:                        known_op = 1'b0;
    endcase
  end

  // Counter saturates at 255, so timeouts above 255 can never fire.
  assign timeout = (MEM_TIMEOUT != 0) && ({24'd0, wait_cnt} == MEM_TIMEOUT) && !mem_ready;

  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    rden1_c   = 1'b0;
    ir_we_c   = 1'b0;
    rden2_c   = 1'b0;
    we2_c     = 1'b0;
    pc_we_c   = 1'b0;
    rf_we_c   = 1'b0;
    csr_we_c  = 1'b0;
    mret_c    = 1'b0;
    int_c     = 1'b0;
    err_c     = 1'b0;
    case (state)
      S_FETCH: begin
        rden1_c = 1'b1;
        if (mem_ready) begin
          ir_we_c   = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (opcode == OP_LOAD) begin
          rden2_c   = 1'b1;
          state_nxt = S_MEM;
        end else if (opcode == OP_STORE) begin
          we2_c     = 1'b1;
          state_nxt = S_MEM;
        end else begin
          complete = 1'b1;
          pc_we_c  = 1'b1;
          rf_we_c  = dec_rf_we & known_op;
          csr_we_c = dec_csr_en & known_op;
          mret_c   = dec_is_mret;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          rden2_c  = mem_is_load;
          we2_c    = !mem_is_load;
          pc_we_c  = 1'b1;
          rf_we_c  = mem_is_load;
          complete = 1'b1;
        end else if (timeout) begin
          err_c    = 1'b1;
          pc_we_c  = 1'b1;
          complete = 1'b1;
        end else begin
          rden2_c = mem_is_load;
          we2_c   = !mem_is_load;
        end
      end
      default: begin
        int_c     = 1'b1;
        pc_we_c   = 1'b1;
        state_nxt = S_FETCH;
      end
    endcase
    // Interrupts are only considered at instruction boundaries.
    if (complete)
      state_nxt = (intr && csr_mie && !mret_c) ? S_INTR : S_FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      wait_cnt    <= 8'd0;
      mem_is_load <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_EXEC) begin
        wait_cnt    <= 8'd0;
        mem_is_load <= (opcode == OP_LOAD);
      end else if (state == S_MEM && !mem_ready && wait_cnt != 8'hFF) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  // Outputs are forced low while reset is held, whatever the inputs do.
  assign mem_rden1 = rden1_c  & rst_n;
  assign ir_we     = ir_we_c  & rst_n;
  assign mem_rden2 = rden2_c  & rst_n;
  assign mem_we2   = we2_c    & rst_n;
  assign pc_we     = pc_we_c  & rst_n;
  assign rf_we     = rf_we_c  & rst_n;
  assign csr_we    = csr_we_c & rst_n;
  assign mret_exec = mret_c   & rst_n;
  assign int_taken = int_c    & rst_n;
  assign bus_err   = err_c    & rst_n;
  assign state_o   = state;

endmodule
